// File: rtl/sample_mem_slave_if.sv
// rtl/sample_mem_slave_if.sv - Avalon-MM style bus bundle for sample_mem_slave
//
// Purpose: groups the request/response signals of the sample buffer bus.
// Signals:
//   address       24-bit byte address (master -> slave)
//   read, write   request strobes (master -> slave)
//   writedata     32-bit write data (master -> slave)
//   waitrequest   request not accepted this cycle (slave -> master)
//   readdata      32-bit read response data (slave -> master)
//   readdatavalid readdata valid this cycle (slave -> master)
interface sample_mem_slave_if;
  logic [23:0] address;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic        waitrequest;
  logic [31:0] readdata;
  logic        readdatavalid;

  modport master (
    output address, read, write, writedata,
    input  waitrequest, readdata, readdatavalid
  );

  modport slave (
    input  address, read, write, writedata,
    output waitrequest, readdata, readdatavalid
  );
endinterface

// File: rtl/sample_mem_slave.sv
// rtl/sample_mem_slave.sv - on-chip sample buffer behind an Avalon-MM slave port
//
// Purpose: 2^DEPTH_LOG2 x 32-bit buffer with pipelined reads (fixed
// READ_LATENCY, at most MAX_PENDING in flight), in-order responses and
// request/error counters.
// Ports:
//   clk        clock, all state changes on rising edge
//   reset      synchronous, active-high reset
//   bus        sample_mem_slave_if.slave (address/read/write/writedata in,
//              waitrequest/readdata/readdatavalid out)
//   rd_count   accepted reads, wraps modulo 2^32
//   wr_count   accepted writes, wraps modulo 2^32
//   err_count  protocol/range errors, saturates at 0xFFFF
// Build option: define SAMPLE_MEM_STALL_EN to add LFSR-driven random stalls.
module sample_mem_slave #(
  parameter int DEPTH_LOG2   = 10,
  parameter int READ_LATENCY = 3,
  parameter int MAX_PENDING  = 2
) (
  input  logic              clk,
  input  logic              reset,
  sample_mem_slave_if.slave bus,
  output logic [31:0]       rd_count,
  output logic [31:0]       wr_count,
  output logic [15:0]       err_count
);

  localparam int          WORDS    = 1 << DEPTH_LOG2;
  localparam logic [31:0] OOR_DATA = 32'hDEAD_BEEF;

  logic [31:0] mem [WORDS];

  // Read pipeline: stage READ_LATENCY-1 drives the response. Data registers
  // only load when a valid entry moves in, so the last stage keeps the most
  // recent response and readdata holds between responses.
  logic [READ_LATENCY-1:0] pipe_v;
  logic [31:0]             pipe_d [READ_LATENCY];

  logic [3:0] pending;

  logic [DEPTH_LOG2-1:0] word_idx;
  logic                  in_range;
  logic                  stall;
  logic                  rdv_now;
  logic                  accept;
  logic                  wr_acc;
  logic                  rd_acc;
  logic                  err_ev;

  assign word_idx = bus.address[DEPTH_LOG2+1:2];
  assign in_range = ((bus.address >> (DEPTH_LOG2 + 2)) == 24'd0) &&
                    (bus.address[1:0] == 2'b00);

`ifdef SAMPLE_MEM_STALL_EN
  // Fibonacci LFSR, taps 16,14,13,11 (bits 0,2,3,5 in right-shift form).
  logic [15:0] lfsr;

  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr <= 16'hACE1;
    end else begin
      lfsr <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
    end
  end

  assign stall = (bus.read | bus.write) & lfsr[0];
`else
  assign stall = 1'b0;
`endif

  assign rdv_now = pipe_v[READ_LATENCY-1];

  // A retiring response frees a slot in the same cycle, so a full pipeline
  // only blocks reads when nothing is leaving.
  assign bus.waitrequest = reset |
                           (bus.read & (pending == 4'(MAX_PENDING)) & ~rdv_now) |
                           stall;

  assign accept = (bus.read | bus.write) & ~bus.waitrequest;
  // Simultaneous read+write performs only the write; the read is dropped.
  assign wr_acc = accept & bus.write;
  assign rd_acc = accept & bus.read & ~bus.write;
  // One error event per accepted request, however many faults it carries.
  assign err_ev = accept & ((bus.read & bus.write) | ~in_range);

  assign bus.readdatavalid = rdv_now & ~reset;
  assign bus.readdata      = reset ? 32'd0 : pipe_d[READ_LATENCY-1];

  // Buffer contents survive reset; acceptance already excludes reset cycles.
  always_ff @(posedge clk) begin
    if (wr_acc && in_range) begin
      mem[word_idx] <= bus.writedata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pipe_v                 <= '0;
      pipe_d[READ_LATENCY-1] <= 32'd0;
    end else begin
      pipe_v[0] <= rd_acc;
      if (rd_acc) begin
        pipe_d[0] <= in_range ? mem[word_idx] : OOR_DATA;
      end
      for (int i = 1; i < READ_LATENCY; i++) begin
        pipe_v[i] <= pipe_v[i-1];
        if (pipe_v[i-1]) begin
          pipe_d[i] <= pipe_d[i-1];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pending <= 4'd0;
    end else begin
      case ({rd_acc, rdv_now})
        2'b10:   pending <= pending + 4'd1;
        2'b01:   pending <= pending - 4'd1;
        default: pending <= pending;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_count  <= 32'd0;
      wr_count  <= 32'd0;
      err_count <= 16'd0;
    end else begin
      if (rd_acc) begin
        rd_count <= rd_count + 32'd1;
      end
      if (wr_acc) begin
        wr_count <= wr_count + 32'd1;
      end
      if (err_ev && (err_count != 16'hFFFF)) begin
        err_count <= err_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_sample_mem_slave.sv
// tb/tb_sample_mem_slave.sv - self-checking bench for sample_mem_slave
module tb_sample_mem_slave;
  localparam int L    = 3;
  localparam int MAXP = 2;
  localparam int DL   = 10;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  sample_mem_slave_if bus ();
  logic [31:0] rd_count;
  logic [31:0] wr_count;
  logic [15:0] err_count;

  sample_mem_slave #(.DEPTH_LOG2(DL), .READ_LATENCY(L), .MAX_PENDING(MAXP)) dut (
    .clk(clk), .reset(reset), .bus(bus),
    .rd_count(rd_count), .wr_count(wr_count), .err_count(err_count)
  );

  int compared = 0;
  int mismatched = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int          due;
    logic [31:0] data;
  } resp_t;

  resp_t       rq[$];
  logic [31:0] mref [int];
  int          cyc = 0;
  bit          started = 0;
  logic [31:0] m_rd, m_wr, m_last;
  logic [15:0] m_err;
`ifdef SAMPLE_MEM_STALL_EN
  logic [15:0] m_lfsr;
`endif

  function automatic bit ref_in_range(input logic [23:0] a);
    return (int'(a) < (4 << DL)) && (int'(a) % 4 == 0);
  endfunction

  function automatic bit retiring();
    return (rq.size() > 0) && (rq[0].due == cyc);
  endfunction

  function automatic bit exp_wait();
    bit w;
    w = reset || (bus.read && (rq.size() == MAXP) && !retiring());
`ifdef SAMPLE_MEM_STALL_EN
    w = w || ((bus.read || bus.write) && m_lfsr[0]);
`endif
    return w;
  endfunction

  always @(posedge clk) begin : model
    bit acc;
    bit ok;
    int idx;
    if (reset) begin
      rq.delete();
      m_rd = 0; m_wr = 0; m_err = 0; m_last = 0;
`ifdef SAMPLE_MEM_STALL_EN
      m_lfsr = 16'hACE1;
`endif
    end else begin
      acc = (bus.read || bus.write) && !exp_wait();
      if (retiring()) begin
        m_last = rq[0].data;
        void'(rq.pop_front());
      end
      if (acc) begin
        ok  = ref_in_range(bus.address);
        idx = int'(bus.address) / 4;
        if (bus.write) begin
          m_wr = m_wr + 1;
          if (ok) mref[idx] = bus.writedata;
        end else begin
          m_rd = m_rd + 1;
          rq.push_back('{cyc + L, ok ? mref[idx] : 32'hDEADBEEF});
        end
        if (((bus.read && bus.write) || !ok) && m_err != 16'hFFFF) m_err = m_err + 1;
      end
`ifdef SAMPLE_MEM_STALL_EN
      m_lfsr = {m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5], m_lfsr[15:1]};
`endif
    end
    cyc++;
    started = 1;
  end

  // ---------------- per-cycle compare ----------------
  logic [31:0] log_data[$];
  int          log_cyc[$];

  always @(negedge clk) begin : compare
    logic        exp_rdv;
    logic [31:0] exp_rd;
    if (started) begin
      exp_rdv = !reset && retiring();
      if (reset) exp_rd = 32'd0;
      else if (exp_rdv) exp_rd = rq[0].data;
      else exp_rd = m_last;
      check("waitrequest", bus.waitrequest, exp_wait());
      check("readdatavalid", bus.readdatavalid, exp_rdv);
      check("readdata", bus.readdata, exp_rd);
      check("rd_count", rd_count, m_rd);
      check("wr_count", wr_count, m_wr);
      check("err_count", err_count, m_err);
      if (bus.readdatavalid === 1'b1) begin
        log_data.push_back(bus.readdata);
        log_cyc.push_back(cyc);
      end
    end
  end

  // ---------------- driver ----------------
  int last_acc = 0;
  int wait_cnt = 0;

  task automatic issue(input bit r, input bit w, input logic [23:0] a, input logic [31:0] d);
    bit done = 0;
    bus.read = r; bus.write = w; bus.address = a; bus.writedata = d;
    for (int n = 0; n < 64 && !done; n++) begin
      @(negedge clk);
      if (!bus.waitrequest) begin
        done = 1;
        last_acc = cyc;
      end else begin
        wait_cnt++;
      end
      @(posedge clk); #1;
    end
    check("accept_timeout", 32'(done), 32'd1);
  endtask

  task automatic idle(input int n);
    bus.read = 1'b0; bus.write = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic expect_resp(input string name, input int idx, input logic [31:0] exp);
    check({name, "_present"}, 32'(log_data.size() > idx), 32'd1);
    if (log_data.size() > idx) check(name, log_data[idx], exp);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int base, acc_rd, n_rand_reads, op, word;
    logic [31:0] d, tmp;
    logic [23:0] a;

    bus.read = 0; bus.write = 0; bus.address = 0; bus.writedata = 0;
    @(posedge clk); #1;
    @(negedge clk);
    check("rst_waitrequest", bus.waitrequest, 1);
    check("rst_readdatavalid", bus.readdatavalid, 0);
    check("rst_readdata", bus.readdata, 0);
    check("rst_rd_count", rd_count, 0);
    check("rst_err_count", err_count, 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // write then read next cycle
    base = log_data.size();
    issue(0, 1, 24'h10, 32'h12345678);
    issue(1, 0, 24'h10, 0);
    acc_rd = last_acc;
    idle(6);
    expect_resp("raw_data", base, 32'h12345678);
    if (log_cyc.size() > base) check("raw_latency", 32'(log_cyc[base] - acc_rd), 32'd3);
    check("raw_wr_count", wr_count, 1);
    check("raw_rd_count", rd_count, 1);

    // back-to-back reads against the pending limit
    for (int i = 0; i < 4; i++) issue(0, 1, 24'(4 * i), 32'hA0000000 + 32'(i));
    base = log_data.size();
    wait_cnt = 0;
    for (int i = 0; i < 4; i++) issue(1, 0, 24'(4 * i), 0);
    idle(8);
    check("b2b_wait_cycles", 32'(wait_cnt), 32'd1);
    for (int i = 0; i < 4; i++) expect_resp("b2b_data", base + i, 32'hA0000000 + 32'(i));
    check("b2b_rd_count", rd_count, 5);

    // out-of-range read and misaligned write
    base = log_data.size();
    issue(1, 0, 24'h001000, 0);
    issue(0, 1, 24'h000002, 32'hFFFFFFFF);
    issue(1, 0, 24'h000000, 0);
    idle(6);
    expect_resp("oor_data", base, 32'hDEADBEEF);
    expect_resp("word0_kept", base + 1, 32'hA0000000);
    check("oor_err_count", err_count, 2);

    // read and write together
    base = log_data.size();
    issue(1, 1, 24'h20, 32'hA5A5A5A5);
    idle(5);
    check("rw_no_resp", 32'(log_data.size()), 32'(base));
    check("rw_err_count", err_count, 3);
    issue(1, 0, 24'h20, 0);
    idle(5);
    expect_resp("rw_word8", base, 32'hA5A5A5A5);

    // reset with reads in flight
    base = log_data.size();
    issue(1, 0, 24'h0, 0);
    issue(1, 0, 24'h4, 0);
    bus.read = 0; reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    idle(6);
    check("rst_flush_no_resp", 32'(log_data.size()), 32'(base));
    check("rst_flush_rd_count", rd_count, 0);
    check("rst_flush_wr_count", wr_count, 0);
    check("rst_flush_err_count", err_count, 0);
    issue(1, 0, 24'h10, 0);
    idle(5);
    expect_resp("rst_keeps_mem", base, 32'h12345678);

    // randomized traffic
    for (int i = 0; i < 64; i++) begin
      d = $urandom;
      issue(0, 1, 24'(4 * i), d);
    end
    base = log_data.size();
    n_rand_reads = 0;
    for (int k = 0; k < 800; k++) begin
      op   = $urandom_range(0, 9);
      word = $urandom_range(0, 63);
      a    = 24'(word * 4);
      d    = $urandom;
      tmp  = $urandom;
      if (op <= 3) begin
        issue(1, 0, a, 0);
        n_rand_reads++;
      end else if (op <= 6) begin
        issue(0, 1, a, d);
      end else if (op == 7) begin
        issue(1, 1, a, d);
      end else if (op == 8) begin
        if (tmp[0]) a = tmp[23:0] | 24'h001000;
        else a = a + 24'($urandom_range(1, 3));
        if (tmp[1]) begin
          issue(1, 0, a, 0);
          n_rand_reads++;
        end else begin
          issue(0, 1, a, d);
        end
      end else begin
        idle(1);
      end
    end
    idle(10);
    check("rand_resp_count", 32'(log_data.size() - base), 32'(n_rand_reads));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
